// File: rtl/multdiv_ctrl_if.sv
// Handshake and data bundle between the pipeline, the multdiv unit and multdiv_ctrl.
// The slave modport is the controller; the master modport is the pipeline/multdiv side.
interface multdiv_ctrl_if;
    logic        issue_valid;
    logic        issue_is_div;
    logic [31:0] issue_a;
    logic [31:0] issue_b;
    logic [4:0]  issue_rd;
    logic        flush;

    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic        md_ctrl_mult;
    logic        md_ctrl_div;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_resultRDY;

    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exception;
    logic        wb_ack;
    logic        busy;

    modport master (
        output issue_valid, issue_is_div, issue_a, issue_b, issue_rd, flush,
        output md_result, md_exception, md_resultRDY, wb_ack,
        input  md_operandA, md_operandB, md_ctrl_mult, md_ctrl_div,
        input  stall, wb_valid, wb_rd, wb_data, wb_exception, busy
    );

    modport slave (
        input  issue_valid, issue_is_div, issue_a, issue_b, issue_rd, flush,
        input  md_result, md_exception, md_resultRDY, wb_ack,
        output md_operandA, md_operandB, md_ctrl_mult, md_ctrl_div,
        output stall, wb_valid, wb_rd, wb_data, wb_exception, busy
    );
endinterface

// File: rtl/multdiv_ctrl.sv
// Sequences one mult/div through the iterative multdiv unit, stalls the pipeline
// meanwhile and presents a writeback record (rstatus write on exception/timeout).
//
// state | meaning
// IDLE  | waiting for a mult/div in DX
// START | one-cycle start pulse to multdiv
// BUSY  | waiting for md_resultRDY or timeout
// DONE  | writeback record valid until wb_ack
module multdiv_ctrl #(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int CNT_W          = 6
) (
    input  logic          clock,
    input  logic          reset,
    multdiv_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [4:0]       RSTATUS  = 5'd30;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             is_div;
    logic [4:0]       rd;
    logic [31:0]      exc_code;

    assign exc_code = is_div ? 32'd5 : 32'd4;

    always_comb begin
        bus.stall = 1'b0;
        case (state)
            IDLE:    bus.stall = bus.issue_valid;
            START:   bus.stall = 1'b1;
            BUSY:    bus.stall = 1'b1;
            DONE:    bus.stall = ~bus.wb_ack;
            default: bus.stall = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state            <= IDLE;
            count            <= '0;
            is_div           <= 1'b0;
            rd               <= 5'd0;
            bus.md_operandA  <= 32'd0;
            bus.md_operandB  <= 32'd0;
            bus.md_ctrl_mult <= 1'b0;
            bus.md_ctrl_div  <= 1'b0;
            bus.wb_valid     <= 1'b0;
            bus.wb_rd        <= 5'd0;
            bus.wb_data      <= 32'd0;
            bus.wb_exception <= 1'b0;
            bus.busy         <= 1'b0;
        end else begin
            bus.md_ctrl_mult <= 1'b0;
            bus.md_ctrl_div  <= 1'b0;
            if (bus.flush && state != IDLE) begin
                // flush wins over md_resultRDY and wb_ack
                state            <= IDLE;
                count            <= '0;
                bus.busy         <= 1'b0;
                bus.wb_valid     <= 1'b0;
                bus.wb_rd        <= 5'd0;
                bus.wb_data      <= 32'd0;
                bus.wb_exception <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.issue_valid && !bus.flush) begin
                            bus.md_operandA  <= bus.issue_a;
                            bus.md_operandB  <= bus.issue_b;
                            is_div           <= bus.issue_is_div;
                            rd               <= bus.issue_rd;
                            bus.md_ctrl_div  <= bus.issue_is_div;
                            bus.md_ctrl_mult <= ~bus.issue_is_div;
                            bus.busy         <= 1'b1;
                            state            <= START;
                        end
                    end
                    START: begin
                        count <= '0;
                        state <= BUSY;
                    end
                    BUSY: begin
                        if (count != CNT_MAX) begin
                            count <= count + 1'b1;
                        end
                        if (bus.md_resultRDY) begin
                            state        <= DONE;
                            bus.wb_valid <= 1'b1;
                            if (bus.md_exception) begin
                                bus.wb_rd        <= RSTATUS;
                                bus.wb_data      <= exc_code;
                                bus.wb_exception <= 1'b1;
                            end else begin
                                bus.wb_rd        <= rd;
                                bus.wb_data      <= bus.md_result;
                                bus.wb_exception <= 1'b0;
                            end
                        end else if (count == CNT_LAST) begin
                            state            <= DONE;
                            bus.wb_valid     <= 1'b1;
                            bus.wb_rd        <= RSTATUS;
                            bus.wb_data      <= exc_code;
                            bus.wb_exception <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (bus.wb_ack) begin
                            state            <= IDLE;
                            bus.busy         <= 1'b0;
                            bus.wb_valid     <= 1'b0;
                            bus.wb_rd        <= 5'd0;
                            bus.wb_data      <= 32'd0;
                            bus.wb_exception <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: mult/div completion, exception, timeout,
// delayed ack, flush and mid-operation reset.
module tb_multdiv_ctrl;
    logic clock;
    logic reset;
    int   checks;
    int   passed;
    int   n_mult;
    int   n_div;
    int   bad;

    multdiv_ctrl_if bus ();

    multdiv_ctrl #(.TIMEOUT_CYCLES(40), .CNT_W(6)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
        if (bus.md_ctrl_mult === 1'b1) n_mult++;
        if (bus.md_ctrl_div === 1'b1) n_div++;
    endtask

    task automatic set_issue(input logic div, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd);
        bus.issue_valid  = 1'b1;
        bus.issue_is_div = div;
        bus.issue_a      = a;
        bus.issue_b      = b;
        bus.issue_rd     = rd;
    endtask

    initial begin
        checks = 0; passed = 0; n_mult = 0; n_div = 0; bad = 0;
        reset = 1'b0;
        bus.issue_valid = 0; bus.issue_is_div = 0; bus.issue_a = 0; bus.issue_b = 0;
        bus.issue_rd = 0; bus.flush = 0; bus.md_result = 0; bus.md_exception = 0;
        bus.md_resultRDY = 0; bus.wb_ack = 0;
        tick; tick;
        reset = 1'b1;
        chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_opA", bus.md_operandA, 32'd0);
        chk("rst_pulse", {30'd0, bus.md_ctrl_mult, bus.md_ctrl_div}, 32'd0);
        chk("rst_stall", {31'd0, bus.stall}, 32'd0);

        // mult 6x7, ready after 17 BUSY cycles, ack same cycle as wb_valid
        n_mult = 0; n_div = 0;
        set_issue(1'b0, 32'd6, 32'd7, 5'd3);
        #1 chk("t1_stall_issue", {31'd0, bus.stall}, 32'd1);
        tick;
        chk("t1_pulse_mult", {31'd0, bus.md_ctrl_mult}, 32'd1);
        chk("t1_pulse_div", {31'd0, bus.md_ctrl_div}, 32'd0);
        chk("t1_opA", bus.md_operandA, 32'd6);
        chk("t1_opB", bus.md_operandB, 32'd7);
        chk("t1_busy", {31'd0, bus.busy}, 32'd1);
        tick;
        bad = 0;
        for (int k = 1; k <= 16; k++) begin
            if (bus.stall !== 1'b1 || bus.wb_valid !== 1'b0) bad++;
            tick;
        end
        bus.md_resultRDY = 1; bus.md_result = 32'd42;
        tick;
        bus.md_resultRDY = 0;
        chk("t1_busy_window", bad, 32'd0);
        chk("t1_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        chk("t1_wb_rd", {27'd0, bus.wb_rd}, 32'd3);
        chk("t1_wb_data", bus.wb_data, 32'd42);
        chk("t1_wb_exc", {31'd0, bus.wb_exception}, 32'd0);
        chk("t1_stall_done", {31'd0, bus.stall}, 32'd1);
        bus.wb_ack = 1; bus.issue_valid = 0;
        #1 chk("t1_stall_ack", {31'd0, bus.stall}, 32'd0);
        tick;
        bus.wb_ack = 0;
        chk("t1_idle_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("t1_idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("t1_n_mult", n_mult, 32'd1);
        chk("t1_n_div", n_div, 32'd0);

        // div 10/0 with exception, minimum latency
        n_mult = 0; n_div = 0;
        set_issue(1'b1, 32'd10, 32'd0, 5'd7);
        tick;
        chk("t2_pulse_div", {31'd0, bus.md_ctrl_div}, 32'd1);
        bus.md_resultRDY = 1; bus.md_exception = 1; bus.md_result = 32'hdead;
        tick; tick;
        bus.md_resultRDY = 0; bus.md_exception = 0;
        chk("t2_wb_valid_lat3", {31'd0, bus.wb_valid}, 32'd1);
        chk("t2_wb_rd", {27'd0, bus.wb_rd}, 32'd30);
        chk("t2_wb_data", bus.wb_data, 32'd5);
        chk("t2_wb_exc", {31'd0, bus.wb_exception}, 32'd1);
        bus.wb_ack = 1; bus.issue_valid = 0;
        tick;
        bus.wb_ack = 0;
        chk("t2_n_div", n_div, 32'd1);
        chk("t2_n_mult", n_mult, 32'd0);
        chk("t2_idle", {31'd0, bus.wb_valid}, 32'd0);

        // timeout on a mult
        set_issue(1'b0, 32'd1, 32'd2, 5'd6);
        tick; tick;
        repeat (39) tick;
        chk("t3_pre_timeout", {31'd0, bus.wb_valid}, 32'd0);
        chk("t3_busy", {31'd0, bus.busy}, 32'd1);
        tick;
        chk("t3_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        chk("t3_wb_rd", {27'd0, bus.wb_rd}, 32'd30);
        chk("t3_wb_data", bus.wb_data, 32'd4);
        chk("t3_wb_exc", {31'd0, bus.wb_exception}, 32'd1);
        bus.wb_ack = 1; bus.issue_valid = 0;
        tick;
        bus.wb_ack = 0;

        // ack delayed 5 cycles; operand changes in DONE must be ignored
        set_issue(1'b0, 32'd100, 32'd3, 5'd9);
        tick;
        bus.md_resultRDY = 1; bus.md_result = 32'd300;
        tick; tick;
        bus.md_resultRDY = 0;
        bus.issue_a = 32'd555;
        bad = 0;
        repeat (5) begin
            #1;
            if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd9 || bus.wb_data !== 32'd300 ||
                bus.wb_exception !== 1'b0 || bus.stall !== 1'b1 || bus.md_operandA !== 32'd100)
                bad++;
            tick;
        end
        chk("t4_hold", bad, 32'd0);
        bus.wb_ack = 1; bus.issue_valid = 0;
        #1 chk("t4_stall_ack", {31'd0, bus.stall}, 32'd0);
        chk("t4_data_ack", bus.wb_data, 32'd300);
        tick;
        bus.wb_ack = 0;
        chk("t4_idle", {31'd0, bus.wb_valid}, 32'd0);
        chk("t4_opA", bus.md_operandA, 32'd100);

        // flush on BUSY cycle 3, RDY afterwards ignored
        set_issue(1'b0, 32'd11, 32'd2, 5'd12);
        tick; tick; tick; tick;
        bus.flush = 1;
        tick;
        bus.flush = 0; bus.issue_valid = 0;
        bus.md_resultRDY = 1; bus.md_result = 32'd77;
        chk("t5_flush_busy", {31'd0, bus.busy}, 32'd0);
        chk("t5_flush_wb", {31'd0, bus.wb_valid}, 32'd0);
        tick;
        bus.md_resultRDY = 0;
        chk("t5_rdy_ignored", {31'd0, bus.wb_valid}, 32'd0);
        chk("t5_still_idle", {31'd0, bus.busy}, 32'd0);
        set_issue(1'b0, 32'd99, 32'd1, 5'd1);
        bus.flush = 1;
        #1 chk("t5_flush_issue_stall", {31'd0, bus.stall}, 32'd1);
        tick;
        bus.flush = 0;
        chk("t5_not_accepted", {31'd0, bus.busy}, 32'd0);
        chk("t5_opA_kept", bus.md_operandA, 32'd11);
        n_mult = 0; n_div = 0;
        set_issue(1'b1, 32'd20, 32'd4, 5'd2);
        tick;
        chk("t5_fresh_pulse", {31'd0, bus.md_ctrl_div}, 32'd1);
        chk("t5_fresh_opA", bus.md_operandA, 32'd20);
        bus.md_resultRDY = 1; bus.md_result = 32'd5;
        tick; tick;
        bus.md_resultRDY = 0;
        chk("t5_wb_rd", {27'd0, bus.wb_rd}, 32'd2);
        chk("t5_wb_data", bus.wb_data, 32'd5);
        chk("t5_wb_exc", {31'd0, bus.wb_exception}, 32'd0);
        bus.wb_ack = 1; bus.issue_valid = 0;
        tick;
        bus.wb_ack = 0;
        chk("t5_n_div", n_div, 32'd1);

        // synchronous reset during BUSY
        set_issue(1'b0, 32'd3, 32'd3, 5'd4);
        tick; tick;
        reset = 1'b0;
        tick;
        reset = 1'b1; bus.issue_valid = 0;
        #1;
        chk("t6_opA", bus.md_operandA, 32'd0);
        chk("t6_opB", bus.md_operandB, 32'd0);
        chk("t6_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("t6_busy", {31'd0, bus.busy}, 32'd0);
        chk("t6_pulse", {30'd0, bus.md_ctrl_mult, bus.md_ctrl_div}, 32'd0);
        chk("t6_wb_rd", {27'd0, bus.wb_rd}, 32'd0);
        chk("t6_stall", {31'd0, bus.stall}, 32'd0);
        bus.md_resultRDY = 1; bus.md_result = 32'd9;
        tick;
        bus.md_resultRDY = 0;
        chk("t6_no_wb", {31'd0, bus.wb_valid}, 32'd0);
        set_issue(1'b0, 32'd8, 32'd8, 5'd5);
        tick;
        bus.md_resultRDY = 1; bus.md_result = 32'd64;
        tick; tick;
        bus.md_resultRDY = 0;
        chk("t6_wb_data", bus.wb_data, 32'd64);
        chk("t6_wb_rd2", {27'd0, bus.wb_rd}, 32'd5);
        bus.wb_ack = 1; bus.issue_valid = 0;
        tick;
        bus.wb_ack = 0;
        chk("t6_final_idle", {31'd0, bus.busy}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Sequencer that connects the iterative multdiv unit to the 5-stage pipeline.
- Accepts a mult/div from the DX stage and registers its operands.
- Pulses the multdiv start control for one cycle, holds the pipeline stalled until the result or exception arrives, and presents a writeback record.
- Converts exceptions and timeouts into a rstatus ($r30) write.

Parameters:
- TIMEOUT_CYCLES, 40, max BUSY cycles before forcing an exception.
- CNT_W, 6, width of the BUSY cycle counter; must hold TIMEOUT_CYCLES.

Ports:
- clock  in  1  master clock, rising edge.
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block.
- issue_valid  in  1  DX holds a mult or div.
- issue_is_div  in  1  1=div, 0=mult.
- issue_a  in  32  operand A (already bypassed).
- issue_b  in  32  operand B (already bypassed).
- issue_rd  in  5  destination register.
- flush  in  1  squash in-flight op.
- md_operandA  out  32  to multdiv.
- md_operandB  out  32  to multdiv.
- md_ctrl_mult  out  1  one-cycle start pulse.
- md_ctrl_div  out  1  one-cycle start pulse.
- md_result  in  32  multdiv result.
- md_exception  in  1  multdiv exception (ovf/div0).
- md_resultRDY  in  1  result valid.
- stall  out  1  hold PC, FD and DX.
- wb_valid  out  1  writeback record valid.
- wb_rd  out  5  writeback register.
- wb_data  out  32  writeback data.
- wb_exception  out  1  record is an exception.
- wb_ack  in  1  pipeline consumed the record.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset==0 at an edge, any state): state=IDLE, counter=0, all registered outputs 0. Mid-operation reset abandons the op; no wb_valid is produced.
- States: IDLE, START, BUSY, DONE. State is 2-bit encoded.
- IDLE:
  - If issue_valid: latch issue_a/issue_b into md_operandA/B, latch issue_is_div and issue_rd, go to START.
  - Otherwise stay in IDLE.
- START:
  - md_ctrl_div=is_div and md_ctrl_mult=~is_div, for exactly one cycle; both are 0 in every other state.
  - counter<=0, go to BUSY.
- BUSY:
  - counter increments each cycle and saturates.
  - md_resultRDY==1: capture md_result and md_exception, go to DONE. md_resultRDY is ignored outside BUSY.
  - Else counter==TIMEOUT_CYCLES-1: capture exception=1, go to DONE.
- DONE:
  - wb_valid=1. The record is held stable until wb_ack.
  - wb_ack==1: go to IDLE; the record is dropped on that edge.
- Writeback record:
  - No exception: wb_rd=latched rd, wb_data=captured result, wb_exception=0.
  - Exception or timeout: wb_rd=5'd30, wb_data=32'd5 for div, 32'd4 for mult, wb_exception=1.
- stall (combinational) = (IDLE & issue_valid) | START | BUSY | (DONE & ~wb_ack).
  - Stall drops in the wb_ack cycle, so the stalled mult/div leaves DX on that edge and is not reissued.
- issue_valid in START, BUSY or DONE is ignored; operands are never overwritten while an op is in flight.
- flush==1 at an edge in any non-IDLE state: go to IDLE, discard result, wb_valid=0 next cycle. flush has priority over md_resultRDY and wb_ack.
- flush in IDLE together with issue_valid: the op is not accepted; stall is still combinationally high that cycle.
- Latency: issue edge→START (1), START→BUSY (1), BUSY for N cycles until md_resultRDY, then DONE. Minimum issue-to-wb_valid is 3 cycles when md_resultRDY is seen in the first BUSY cycle.
- md_operandA/B hold their value until the next accepted issue.

Test Plan:
- Mult 6×7, rd=3, md_resultRDY after 17 BUSY cycles, wb_ack same cycle as wb_valid → md_ctrl_mult pulses once; stall high through DONE; wb_rd=3, wb_data=42, wb_exception=0; IDLE next cycle.
- Div 10÷0, md_exception=1 with RDY → wb_rd=30, wb_data=5, wb_exception=1; md_ctrl_div pulses once, md_ctrl_mult never.
- md_resultRDY never asserted, TIMEOUT_CYCLES=40 → DONE after 40 BUSY cycles with wb_rd=30, wb_data=4 for mult.
- wb_ack delayed 5 cycles, issue_a changed during DONE → record stable for all 5 cycles; md_operandA unchanged; stall high until the ack cycle.
- flush on BUSY cycle 3, then md_resultRDY on cycle 4 → IDLE, wb_valid stays 0, RDY ignored; next issue produces a fresh start pulse.
- reset=0 for one edge during BUSY → all outputs 0 next cycle, state IDLE; a following issue completes normally.
